// File: rtl/v74x148_seq_encoder.sv
`default_nettype none
// ============================================================================
// Module   : v74x148_seq_encoder
// Purpose  : Sequential 74x148-style priority encoder. It synchronizes the
//            asynchronous active-low request lines and captures the
//            highest-priority request into a held code (A/VALID). The code
//            stays frozen until the consumer acknowledges it, and the encoder
//            then waits for the captured line to be released before it can
//            capture again.
// Options  : define V74X148_SEQ_DEBOUNCE_EN to add a stability filter. The
//            synchronized request vector must then be unchanged for
//            DEB_CYCLES edges before it is captured.
// Revision : 1.0 - initial release
// ============================================================================
module v74x148_seq_encoder #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       EI_L,
  input  logic [7:0] I_L,
  input  logic       ACK,
  output logic [2:0] A,
  output logic       VALID,
  output logic       GS_L,
  output logic       EO_L
);

  localparam logic [7:0] ALL_IDLE = 8'hFF;

  // The filter length must be at least one edge.
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("v74x148_seq_encoder: DEB_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] code_nxt;
  logic       valid_nxt;
  logic       gs_nxt, eo_nxt;

  logic [7:0] sync_meta;   // first synchronizer stage, may be metastable
  logic [7:0] sync_req;    // second stage, safe to use
  logic       any_req;
  logic [2:0] top_idx;
  logic       capture_ok;

  // Return the index of the highest active (low) bit, 0 if none are active.
  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  // Two-flop synchronizer; resets to the idle (all high) level.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      sync_meta <= ALL_IDLE;
      sync_req  <= ALL_IDLE;
    end else begin
      sync_meta <= I_L;
      sync_req  <= sync_meta;
    end
  end

  assign any_req = (sync_req != ALL_IDLE);
  assign top_idx = prio_idx(sync_req);

`ifdef V74X148_SEQ_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_CYCLES - 1);

  logic [7:0]       deb_prev;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_same;

  // An edge counts towards stability only if the vector repeats and shows
  // at least one active request.
  assign deb_same = (sync_req == deb_prev) && any_req;

  // Count consecutive stable edges, saturating at the capture threshold.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      deb_prev <= ALL_IDLE;
      deb_cnt  <= '0;
    end else begin
      deb_prev <= sync_req;
      if (!deb_same) begin
        deb_cnt <= '0;
      end else if (deb_cnt != CNT_TOP) begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // The edge that completes DEB_CYCLES stable edges is the capture edge.
  assign capture_ok = deb_same && (deb_cnt == CNT_TOP);
`else
  assign capture_ok = any_req;
`endif

  // State, held code and status flags.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= IDLE;
      A     <= 3'b000;
      VALID <= 1'b0;
      GS_L  <= 1'b1;
      EO_L  <= 1'b1;
    end else begin
      state <= state_nxt;
      A     <= code_nxt;
      VALID <= valid_nxt;
      GS_L  <= gs_nxt;
      EO_L  <= eo_nxt;
    end
  end

  // Next-state and output logic; disable overrides everything, ACK included.
  always_comb begin
    state_nxt = state;
    code_nxt  = A;
    valid_nxt = VALID;
    // Group-select / enable-out follow the live synchronized vector.
    gs_nxt    = EI_L | ~any_req;
    eo_nxt    = EI_L | any_req;

    if (EI_L) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture_ok) begin
            code_nxt  = top_idx;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (ACK) begin
            valid_nxt = 1'b0;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          // Wait for the acknowledged line itself to go inactive.
          if (sync_req[A]) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_v74x148_seq_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_v74x148_seq_encoder
// Purpose  : Self-checking bench for v74x148_seq_encoder: directed scenarios
//            plus random stimulus compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v74x148_seq_encoder;

  localparam int DEB = 4;

  logic       CLK;
  logic       RESET_L;
  logic       EI_L;
  logic [7:0] I_L;
  logic       ACK;
  logic [2:0] A;
  logic       VALID;
  logic       GS_L;
  logic       EO_L;

  int n_chk;
  int n_pass;

  v74x148_seq_encoder #(.DEB_CYCLES(DEB)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .EI_L    (EI_L),
    .I_L     (I_L),
    .ACK     (ACK),
    .A       (A),
    .VALID   (VALID),
    .GS_L    (GS_L),
    .EO_L    (EO_L)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: history of the raw inputs seen at previous edges and a
  // description of what the consumer-side handshake is waiting for.
  logic [7:0] seen_1, seen_2;   // I_L at the previous edge and the one before
  logic [7:0] last_view;        // synchronized view at the previous edge
  int         run_len;          // edges the non-idle view has stayed the same
  logic       has_code;         // a code is presented, waiting for ACK
  logic       awaiting_release; // acknowledged, waiting for the line to drop
  logic [2:0] m_a;
  logic       m_valid, m_gs, m_eo;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    seen_1 = 8'hFF; seen_2 = 8'hFF; last_view = 8'hFF; run_len = 0;
    has_code = 1'b0; awaiting_release = 1'b0;
    m_a = 3'd0; m_valid = 1'b0; m_gs = 1'b1; m_eo = 1'b1;
  endtask

  // Highest index whose line is low, scanning from the top.
  function automatic logic [2:0] highest_low(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (!v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_edge(input logic ei, input logic ack, input logic [7:0] il);
    logic [7:0] view;
    logic       ready;
    view = seen_2;   // a raw level reaches the logic two edges after sampling
    m_gs = ei || (view == 8'hFF);
    m_eo = ei || (view != 8'hFF);
    if (view != 8'hFF && view == last_view) run_len++;
    else run_len = 0;
`ifdef V74X148_SEQ_DEBOUNCE_EN
    ready = (view != 8'hFF) && (run_len >= DEB);
`else
    ready = (view != 8'hFF);
`endif
    if (ei) begin
      has_code = 1'b0; awaiting_release = 1'b0; m_valid = 1'b0;
    end else if (has_code) begin
      if (ack) begin has_code = 1'b0; awaiting_release = 1'b1; m_valid = 1'b0; end
    end else if (awaiting_release) begin
      if (view[m_a]) awaiting_release = 1'b0;
    end else if (ready) begin
      m_a = highest_low(view); m_valid = 1'b1; has_code = 1'b1;
    end
    last_view = view;
    seen_2 = seen_1;
    seen_1 = il;
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input logic ei, input logic ack, input logic [7:0] il);
    @(negedge CLK);
    EI_L = ei; ACK = ack; I_L = il;
    @(posedge CLK);
    model_edge(ei, ack, il);
    #1;
    check("A",     {5'd0, A},     {5'd0, m_a});
    check("VALID", {7'd0, VALID}, {7'd0, m_valid});
    check("GS_L",  {7'd0, GS_L},  {7'd0, m_gs});
    check("EO_L",  {7'd0, EO_L},  {7'd0, m_eo});
  endtask

  function automatic logic [7:0] rand_req();
    logic [7:0] v;
    v = 8'hFF;
    case ($urandom_range(0, 3))
      0: v = 8'hFF;
      1, 2: v[$urandom_range(0, 7)] = 1'b0;
      default: begin
        v[$urandom_range(0, 7)] = 1'b0;
        v[$urandom_range(0, 7)] = 1'b0;
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [7:0] cur;
    n_chk = 0; n_pass = 0;
    RESET_L = 1'b0; EI_L = 1'b0; ACK = 1'b0; I_L = 8'hFF;
    model_reset();
    #12;
    check("rst_A",     {5'd0, A},     8'd0);
    check("rst_VALID", {7'd0, VALID}, 8'd0);
    check("rst_GS_L",  {7'd0, GS_L},  8'd1);
    check("rst_EO_L",  {7'd0, EO_L},  8'd1);
    @(negedge CLK); RESET_L = 1'b1;

`ifndef V74X148_SEQ_DEBOUNCE_EN
    // Single request on line 2: code 2 on the third edge.
    step(1'b0, 1'b0, 8'hFB);
    step(1'b0, 1'b0, 8'hFB);
    check("lat_early", {7'd0, VALID}, 8'd0);
    step(1'b0, 1'b0, 8'hFB);
    check("lat_A2",    {5'd0, A},     8'd2);
    check("lat_VALID", {7'd0, VALID}, 8'd1);
    check("lat_GS_L",  {7'd0, GS_L},  8'd0);
    check("lat_EO_L",  {7'd0, EO_L},  8'd1);
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'hFF);

    // Lines 7 and 5: code 7, frozen while line 6 arrives.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h5F);
    check("prio_A7", {5'd0, A}, 8'd7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hBF);
    check("hold_A7", {5'd0, A}, 8'd7);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h7F);
    step(1'b0, 1'b1, 8'h7F);
    check("ack_VALID", {7'd0, VALID}, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h7F);
    check("rel_noVALID", {7'd0, VALID}, 8'd0);
    // Drop line 7 with line 5 active: capture exactly four edges later.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hDF);
    check("recap_early", {7'd0, VALID}, 8'd0);
    step(1'b0, 1'b0, 8'hDF);
    check("recap_A5",    {5'd0, A},     8'd5);
    check("recap_VALID", {7'd0, VALID}, 8'd1);

    // Disable and ACK together while holding.
    step(1'b1, 1'b1, 8'hDF);
    check("dis_VALID", {7'd0, VALID}, 8'd0);
    check("dis_GS_L",  {7'd0, GS_L},  8'd1);
    check("dis_EO_L",  {7'd0, EO_L},  8'd1);
    step(1'b0, 1'b0, 8'hDF);
    check("dis_recap", {7'd0, VALID}, 8'd1);
`else
    // Two-cycle glitch is filtered; a long request is captured.
    step(1'b0, 1'b0, 8'hF7);
    step(1'b0, 1'b0, 8'hF7);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'hFF);
    check("glitch_VALID", {7'd0, VALID}, 8'd0);
    for (int i = 0; i < 3 + DEB; i++) step(1'b0, 1'b0, 8'hF7);
    check("deb_VALID", {7'd0, VALID}, 8'd1);
    check("deb_A3",    {5'd0, A},     8'd3);
`endif

    // Asynchronous reset while a code is held.
    @(negedge CLK); #2;
    RESET_L = 1'b0;
    #1;
    check("arst_A",     {5'd0, A},     8'd0);
    check("arst_VALID", {7'd0, VALID}, 8'd0);
    check("arst_GS_L",  {7'd0, GS_L},  8'd1);
    check("arst_EO_L",  {7'd0, EO_L},  8'd1);
    model_reset();
    @(negedge CLK); RESET_L = 1'b1; I_L = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hFF);

    // Random phase: slowly changing requests, occasional disable, random ACK.
    cur = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) cur = rand_req();
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
